// File: rtl/mux_4_1_rr_arbiter_v_pkg.sv
// Shared definitions for the 4:1 round-robin code mux arbiter.
//   state_t : FSM encoding (IDLE / GRANT / TURN)
//   NUM_REQ : number of requesters sharing the code path
package mux_arb_pkg_v;

  localparam int NUM_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_TURN  = 2'd2
  } state_t;

endpackage

// File: rtl/mux_4_1_rr_arbiter_v_if.sv
// Bus bundle between the requesters and the arbiter.
//   i_req       per-requester request
//   i_code_0..3 requester codes
//   o_gnt       one-hot grant
//   o_sel_code  encoded index of the current/last grant
//   o_en        grant active
//   o_code      registered selected code
//   o_timeout   watchdog release pulse
// Modports: slave = arbiter side, master = requester/stimulus side.
interface mux_4_1_rr_arbiter_v_if
  import mux_arb_pkg_v::*;
#(
  parameter int DATA_W = 8
);
  logic [NUM_REQ-1:0] i_req;
  logic [DATA_W-1:0]  i_code_0;
  logic [DATA_W-1:0]  i_code_1;
  logic [DATA_W-1:0]  i_code_2;
  logic [DATA_W-1:0]  i_code_3;
  logic [NUM_REQ-1:0] o_gnt;
  logic [1:0]         o_sel_code;
  logic               o_en;
  logic [DATA_W-1:0]  o_code;
  logic               o_timeout;

  modport slave (
    input  i_req, i_code_0, i_code_1, i_code_2, i_code_3,
    output o_gnt, o_sel_code, o_en, o_code, o_timeout
  );

  modport master (
    output i_req, i_code_0, i_code_1, i_code_2, i_code_3,
    input  o_gnt, o_sel_code, o_en, o_code, o_timeout
  );
endinterface

// File: rtl/mux_4_1_rr_arbiter_v_rr_pick.sv
// Rotate-priority encoder: finds the first set request bit starting at
// i_ptr and wrapping upward (ptr, ptr+1, ... mod 4).
//   i_req   request vector
//   i_ptr   highest-priority index
//   o_valid any request set
//   o_idx   winning index
module rr_pick_4_v
  import mux_arb_pkg_v::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [1:0]         i_ptr,
  output logic               o_valid,
  output logic [1:0]         o_idx
);

  logic [1:0] cand;

  // Scan from the lowest priority to the highest so the last hit wins.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = 2'd0;
    cand    = 2'd0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = i_ptr + 2'(k);
      if (i_req[cand]) begin
        o_valid = 1'b1;
        o_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux_4_1_rr_arbiter_v.sv
// Round-robin arbiter and sequencer for a 4:1 code mux. Grants one requester
// at a time, drives the select/enable and registers the selected code.
// Optional hold watchdog enabled by defining MUX_ARB_WATCHDOG_EN.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   bus      mux_4_1_rr_arbiter_v_if.slave (requests, codes, grant outputs)
//
// state | meaning
// IDLE  | no grant; pick next requester in rotating order
// GRANT | one requester owns the code path until it drops its request
// TURN  | one dead cycle after a release before the next pick
module mux_4_1_rr_arbiter_v
  import mux_arb_pkg_v::*;
#(
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  mux_4_1_rr_arbiter_v_if.slave   bus
);

  if (MAX_HOLD < 2) begin : g_bad_hold
    $error("MAX_HOLD must be at least 2");
  end

  state_t             state;
  logic [1:0]         ptr;
  logic [NUM_REQ-1:0] gnt_q;
  logic [1:0]         sel_q;
  logic               en_q;
  logic [DATA_W-1:0]  code_q;
  logic               timeout_q;
  logic               pick_valid;
  logic [1:0]         pick_idx;
  logic [DATA_W-1:0]  code_mux;

`ifdef MUX_ARB_WATCHDOG_EN
  localparam int HOLD_W = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  logic [HOLD_W-1:0] hold_cnt;
`endif

  rr_pick_4_v u_pick (
    .i_req   (bus.i_req),
    .i_ptr   (ptr),
    .o_valid (pick_valid),
    .o_idx   (pick_idx)
  );

  always_comb begin
    code_mux = '0;
    case (sel_q)
      2'd0:    code_mux = bus.i_code_0;
      2'd1:    code_mux = bus.i_code_1;
      2'd2:    code_mux = bus.i_code_2;
      default: code_mux = bus.i_code_3;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      ptr       <= 2'd0;
      gnt_q     <= '0;
      sel_q     <= 2'd0;
      en_q      <= 1'b0;
      code_q    <= '0;
      timeout_q <= 1'b0;
`ifdef MUX_ARB_WATCHDOG_EN
      hold_cnt  <= '0;
`endif
    end else begin
      timeout_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            state    <= ST_GRANT;
            gnt_q    <= NUM_REQ'(1) << pick_idx;
            sel_q    <= pick_idx;
            en_q     <= 1'b1;
`ifdef MUX_ARB_WATCHDOG_EN
            hold_cnt <= '0;
`endif
          end
        end
        ST_GRANT: begin
          // Release path: the owner dropped its request (or the watchdog fired).
          // ptr moves past the owner so it only re-wins in rotating order.
          if (!bus.i_req[sel_q]) begin
            state  <= ST_TURN;
            gnt_q  <= '0;
            en_q   <= 1'b0;
            code_q <= '0;
            ptr    <= sel_q + 2'd1;
          end
`ifdef MUX_ARB_WATCHDOG_EN
          else if (hold_cnt == HOLD_W'(MAX_HOLD - 1)) begin
            state     <= ST_TURN;
            gnt_q     <= '0;
            en_q      <= 1'b0;
            code_q    <= '0;
            ptr       <= sel_q + 2'd1;
            timeout_q <= 1'b1;
          end
`endif
          else begin
            code_q   <= code_mux;
`ifdef MUX_ARB_WATCHDOG_EN
            hold_cnt <= hold_cnt + 1'b1;
`endif
          end
        end
        ST_TURN: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_gnt      = gnt_q;
  assign bus.o_sel_code = sel_q;
  assign bus.o_en       = en_q;
  assign bus.o_code     = code_q;
  assign bus.o_timeout  = timeout_q;

endmodule

// File: tb/tb_mux_4_1_rr_arbiter_v.sv
module tb_mux_4_1_rr_arbiter_v;

`ifdef MUX_ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif
  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic [7:0] codes [4];

  int checks = 0;
  int errors = 0;

  mux_4_1_rr_arbiter_v_if #(.DATA_W(8)) bus ();

  assign bus.i_req    = req;
  assign bus.i_code_0 = codes[0];
  assign bus.i_code_1 = codes[1];
  assign bus.i_code_2 = codes[2];
  assign bus.i_code_3 = codes[3];

  mux_4_1_rr_arbiter_v #(.DATA_W(8), .MAX_HOLD(MAX_HOLD)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the path, how many dead cycles remain,
  // rotating start index, and what the registered code must be.
  int         m_owner;
  int         m_dead;
  int         m_ptr;
  int         m_held;
  logic [1:0] m_sel;
  logic [7:0] m_code;
  logic       m_to;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1; m_dead = 0; m_ptr = 0; m_held = 0;
      m_sel = 2'd0; m_code = 8'h00; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner >= 0) begin
        if (!req[m_owner] || (WD && m_held == MAX_HOLD - 1)) begin
          m_to    = WD && req[m_owner];
          m_ptr   = (m_owner + 1) % 4;
          m_owner = -1;
          m_dead  = 1;
          m_code  = 8'h00;
        end else begin
          m_code = codes[m_owner];
          m_held++;
        end
      end else if (m_dead > 0) begin
        m_dead--;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
            m_owner = (m_ptr + k) % 4;
            m_sel   = 2'(m_owner);
            m_held  = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_gnt", 32'(bus.o_gnt), (m_owner >= 0) ? 32'(1 << m_owner) : 32'd0);
      chk("model_en", 32'(bus.o_en), 32'(m_owner >= 0));
      chk("model_sel", 32'(bus.o_sel_code), 32'(m_sel));
      chk("model_code", 32'(bus.o_code), 32'(m_code));
      chk("model_timeout", 32'(bus.o_timeout), 32'(m_to));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Waits (bounded) for o_en; returns number of cycles waited.
  task automatic wait_en(input int budget, output int n);
    n = 0;
    while (!bus.o_en && n < budget) begin
      tick(1);
      n++;
    end
    if (!bus.o_en) chk("wait_en_timeout", 32'(bus.o_en), 32'd1);
  endtask

  task automatic do_reset();
    #1 rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(1);
  endtask

  function automatic int idx_of(input logic [3:0] g);
    int r = -1;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  initial begin
    int n;
    int idx;
    int held;
    int to_seen;
    codes[0] = 8'h80; codes[1] = 8'h40; codes[2] = 8'hC0; codes[3] = 8'h20;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_gnt", 32'(bus.o_gnt), 32'd0);
    chk("rst_sel", 32'(bus.o_sel_code), 32'd0);
    chk("rst_en", 32'(bus.o_en), 32'd0);
    chk("rst_code", 32'(bus.o_code), 32'd0);
    chk("rst_timeout", 32'(bus.o_timeout), 32'd0);
    rst_n = 1'b1;
    tick(1);

    // 1: single request, latency and code lag/tracking
    req = 4'b0001;
    tick(1);
    chk("t1_gnt", 32'(bus.o_gnt), 32'h1);
    chk("t1_sel", 32'(bus.o_sel_code), 32'd0);
    chk("t1_en", 32'(bus.o_en), 32'd1);
    chk("t1_code_lag", 32'(bus.o_code), 32'h00);
    tick(1);
    chk("t1_code", 32'(bus.o_code), 32'h80);
    codes[0] = 8'h81;
    tick(1);
    chk("t1_code_track", 32'(bus.o_code), 32'h81);
    codes[0] = 8'h80;
    req = 4'b0000;
    tick(1);
    chk("t1_drop_en", 32'(bus.o_en), 32'd0);
    chk("t1_drop_code", 32'(bus.o_code), 32'd0);
    tick(2);

    // 2: fairness with all four requesting
    do_reset();
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_en(10, n);
      idx = idx_of(bus.o_gnt);
      chk("t2_order", 32'(idx), 32'(k % 4));
      if (k > 0) chk("t2_dead_cycles", 32'(n), 32'd2);
      tick(2);
      req = 4'b1111 & ~(4'b0001 << (idx & 3));
      tick(1);
      chk("t2_release", 32'(bus.o_en), 32'd0);
      req = 4'b1111;
    end

    // 3: get ptr=2 via requester 1, then 1011 -> requester 3, then 0
    req = 4'b0010;
    wait_en(10, n);
    chk("t3_pre_gnt", 32'(bus.o_gnt), 32'b0010);
    req = 4'b0000;
    tick(1);
    req = 4'b1011;
    wait_en(10, n);
    chk("t3_gnt", 32'(bus.o_gnt), 32'b1000);
    chk("t3_sel", 32'(bus.o_sel_code), 32'd3);
    tick(1);
    chk("t3_code", 32'(bus.o_code), 32'h20);
    req = 4'b0011;
    tick(1);
    wait_en(10, n);
    chk("t3_next_gnt", 32'(bus.o_gnt), 32'b0001);
    req = 4'b0000;
    tick(3);

    // 4: async reset mid-grant
    req = 4'b0100;
    wait_en(10, n);
    tick(2);
    #1 rst_n = 1'b0;
    #1;
    chk("t4_en", 32'(bus.o_en), 32'd0);
    chk("t4_gnt", 32'(bus.o_gnt), 32'd0);
    chk("t4_code", 32'(bus.o_code), 32'd0);
    tick(1);
    rst_n = 1'b1;
    req = 4'b0010;
    wait_en(10, n);
    chk("t4_regrant", 32'(bus.o_gnt), 32'b0010);
    req = 4'b0000;
    tick(3);

    do_reset();
    req = 4'b0001;
    wait_en(10, n);
    held = 0;
    to_seen = 0;
`ifdef MUX_ARB_WATCHDOG_EN
    // 5: watchdog forces release after MAX_HOLD cycles
    while (bus.o_en && held < 40) begin
      held++;
      tick(1);
    end
    chk("t5_hold_len", 32'(held), 32'd16);
    chk("t5_timeout", 32'(bus.o_timeout), 32'd1);
    tick(1);
    chk("t5_timeout_pulse", 32'(bus.o_timeout), 32'd0);
    wait_en(10, n);
    chk("t5_regrant_gap", 32'(n), 32'd1);
    chk("t5_regrant", 32'(bus.o_gnt), 32'b0001);
    req = 4'b0101;
    held = 0;
    while (bus.o_en && held < 40) begin
      held++;
      tick(1);
    end
    chk("t5b_timeout", 32'(bus.o_timeout), 32'd1);
    wait_en(10, n);
    chk("t5b_gnt", 32'(bus.o_gnt), 32'b0100);
`else
    // 6: no watchdog, grant held indefinitely
    while (bus.o_en && held < 110) begin
      if (bus.o_timeout) to_seen++;
      held++;
      tick(1);
    end
    chk("t6_hold_len", 32'(held), 32'd110);
    chk("t6_timeout_seen", 32'(to_seen), 32'd0);
`endif
    req = 4'b0000;
    tick(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
